f2s_pulse_sync_mc: RTL



---
 rtl/f2s_pulse_sync_mc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/f2s_pulse_sync_mc.sv
// f2s_pulse_sync_mc: multi-channel fast(aclk) -> slow(bclk) event synchroniser.
// Each channel queues aclk events in a small counter and ships them one at a
// time over a toggle req/ack handshake, so bursts are not lost and no clock
// is ever gated. Each delivered event is a single-cycle b_pulse in bclk.

// Per-channel transfer engine. Channels share nothing, so the top just tiles
// this block CH times.
module f2s_pulse_sync_ch #(
  parameter int DEPTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int IN_EDGE     = 0
) (
  input  logic rst,
  input  logic aclk,
  input  logic bclk,
  input  logic a_in,
  input  logic a_ovf_clr,
  output logic a_idle,
  output logic a_full,
  output logic a_ovf,
  output logic b_pulse
);

  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CMAX = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } st_t;

  // ---------------- aclk domain ----------------
  st_t           st, st_nxt;
  logic [CW-1:0] cnt;
  logic          a_in_d;
  logic          ev;
  logic          launch;
  logic          accept;
  logic          drop;
  logic          req_t;
  logic          ovf;

  // ack return path: the synchroniser flops are kept in one vector so they
  // can be grouped for CDC constraints.
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // ---------------- bclk domain ----------------
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   req_s_d;
  logic                   ack_t;
  logic                   pulse;

  // Level mode turns each rising edge into one event; pulse mode takes a_in as-is.
  assign ev = (IN_EDGE != 0) ? (a_in & ~a_in_d) : a_in;

  // A launch frees a slot in the same cycle, so a full queue still accepts an
  // event when one leaves simultaneously.
  assign accept = ev & ((cnt != CMAX) | launch);
  assign drop   = ev & (cnt == CMAX) & ~launch;

  // Previous a_in, used only for rising-edge detection.
  always_ff @(posedge aclk or negedge rst)
    if (!rst) a_in_d <= 1'b0;
    else      a_in_d <= a_in;

  // FSM state register.
  always_ff @(posedge aclk or negedge rst)
    if (!rst) st <= IDLE;
    else      st <= st_nxt;

  // Next-state: launch from IDLE whenever something is queued; leave WAIT
  // once the ack toggle has caught up with the req toggle.
  always_comb begin
    st_nxt = st;
    launch = 1'b0;
    case (st)
      IDLE: if (cnt != '0) begin
        launch = 1'b1;
        st_nxt = WAIT;
      end
      WAIT: if (ack_s == req_t) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Pending-event counter: +1 on accept, -1 on launch, both cancel.
  always_ff @(posedge aclk or negedge rst)
    if (!rst) cnt <= '0;
    else begin
      case ({accept, launch})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end

  // Request toggle: one flip per launched event.
  always_ff @(posedge aclk or negedge rst)
    if (!rst)        req_t <= 1'b0;
    else if (launch) req_t <= ~req_t;

  // Sticky overflow; a new drop beats a coincident clear.
  always_ff @(posedge aclk or negedge rst)
    if (!rst)           ovf <= 1'b0;
    else if (drop)      ovf <= 1'b1;
    else if (a_ovf_clr) ovf <= 1'b0;

  // Bring ack_t into aclk.
  always_ff @(posedge aclk or negedge rst)
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_t};

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Status from registered state only.
  assign a_idle = (st == IDLE) && (cnt == '0);
  assign a_full = (cnt == CMAX);
  assign a_ovf  = ovf;

  // Bring req_t into bclk.
  always_ff @(posedge bclk or negedge rst)
    if (!rst) req_sync <= '0;
    else      req_sync <= {req_sync[SYNC_STAGES-2:0], req_t};

  assign req_s = req_sync[SYNC_STAGES-1];

  // Edge of the synchronised toggle becomes a registered one-cycle pulse;
  // the delayed copy is what gets returned as the ack.
  always_ff @(posedge bclk or negedge rst)
    if (!rst) begin
      req_s_d <= 1'b0;
      pulse   <= 1'b0;
      ack_t   <= 1'b0;
    end else begin
      req_s_d <= req_s;
      pulse   <= req_s ^ req_s_d;
      ack_t   <= req_s_d;
    end

  assign b_pulse = pulse;

endmodule

// Top: CH independent channels side by side.
module f2s_pulse_sync_mc #(
  parameter int CH          = 4,
  parameter int DEPTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int IN_EDGE     = 0
) (
  input  logic          rst,
  input  logic          aclk,
  input  logic          bclk,
  input  logic [CH-1:0] a_in,
  input  logic [CH-1:0] a_ovf_clr,
  output logic [CH-1:0] a_idle,
  output logic [CH-1:0] a_full,
  output logic [CH-1:0] a_ovf,
  output logic [CH-1:0] b_pulse
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    f2s_pulse_sync_ch #(
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC_STAGES),
      .IN_EDGE    (IN_EDGE)
    ) u_ch (
      .rst      (rst),
      .aclk     (aclk),
      .bclk     (bclk),
      .a_in     (a_in[g]),
      .a_ovf_clr(a_ovf_clr[g]),
      .a_idle   (a_idle[g]),
      .a_full   (a_full[g]),
      .a_ovf    (a_ovf[g]),
      .b_pulse  (b_pulse[g])
    );
  end

endmodule
